// File: rtl/stack_reg_pkg.sv
// stack_reg_pkg: shared types for the shift-register LIFO (stack_reg_n).
//   stack_op_t   - operation decoded from {push,pop}
//   cell_sel_t   - next-value select for one stack entry
//   count_width  - bits needed to hold an occupancy of 0..depth
package stack_reg_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_t;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_ABOVE = 2'b01,
        SEL_BELOW = 2'b10
    } cell_sel_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_reg_n_if.sv
// stack_reg_n_if: data/control bundle of the LIFO stack.
//   master : drives data_in, push, pop, clear_err (and peek_idx)
//   slave  : drives data_out, count, empty, full, overflow, underflow (and peek_data)
// Optional macro STACK_REG_PEEK_EN adds peek_idx / peek_data.
interface stack_reg_n_if
    import stack_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             pop;
    logic             clear_err;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
`ifdef STACK_REG_PEEK_EN
    logic [$clog2(DEPTH)-1:0] peek_idx;
    logic [WIDTH-1:0]         peek_data;
`endif

    modport master (
        output data_in, push, pop, clear_err,
`ifdef STACK_REG_PEEK_EN
        output peek_idx,
        input  peek_data,
`endif
        input  data_out, count, empty, full, overflow, underflow
    );

    modport slave (
        input  data_in, push, pop, clear_err,
`ifdef STACK_REG_PEEK_EN
        input  peek_idx,
        output peek_data,
`endif
        output data_out, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/stack_reg_cell.sv
// stack_reg_cell: one WIDTH-bit stack entry with async active-high reset.
//   sel_i   - hold / take above_i (shift down on push) / take below_i (shift up on pop)
//   above_i - neighbour nearer the top (data_in for entry 0)
//   below_i - neighbour nearer the bottom (0 for the bottom entry)
//   q_o     - registered entry value
module stack_reg_cell
    import stack_reg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  cell_sel_t        sel_i,
    input  logic [WIDTH-1:0] above_i,
    input  logic [WIDTH-1:0] below_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] ent_q, ent_d;

    always_comb begin
        ent_d = ent_q;
        case (sel_i)
            SEL_ABOVE: ent_d = above_i;
            SEL_BELOW: ent_d = below_i;
            default:   ent_d = ent_q;
        endcase
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) ent_q <= '0;
        else          ent_q <= ent_d;
    end

    assign q_o = ent_q;
endmodule

// File: rtl/stack_reg_n.sv
// stack_reg_n: parametrised LIFO built from a chain of shift-register cells.
// Entry 0 is top-of-stack and drives data_out directly (no read latency).
//   sysclk, sysreset - clock, async active-high reset
//   bus (slave)      - data_in/push/pop/clear_err in; data_out/count/empty/
//                      full/overflow/underflow out
// Optional macro STACK_REG_PEEK_EN adds a combinational read port
// (peek_idx -> peek_data) into any entry.
module stack_reg_n
    import stack_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic         sysclk,
    input  logic         sysreset,
    stack_reg_n_if.slave bus
);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] ent [DEPTH];
    cell_sel_t        sel [DEPTH];
    stack_op_t        op_raw, op_eff;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             empty, full;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign op_raw = stack_op_t'({bus.push, bus.pop});

    // Empty-stack corner cases fold into ordinary ops: a pop on empty moves
    // nothing, a replace on empty behaves exactly like a push.
    always_comb begin
        op_eff = op_raw;
        case (op_raw)
            OP_POP:     op_eff = empty ? OP_NOP  : OP_POP;
            OP_REPLACE: op_eff = empty ? OP_PUSH : OP_REPLACE;
            default:    op_eff = op_raw;
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            case (op_eff)
                OP_PUSH:    sel[i] = SEL_ABOVE;
                OP_POP:     sel[i] = SEL_BELOW;
                OP_REPLACE: sel[i] = (i == 0) ? SEL_ABOVE : SEL_HOLD;
                default:    sel[i] = SEL_HOLD;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        logic [WIDTH-1:0] above, below;
        if (g == 0) begin : g_top
            assign above = bus.data_in;
        end else begin : g_mid
            assign above = ent[g-1];
        end
        // Bottom entry refills with zero so vacated slots stay clear.
        if (g == DEPTH-1) begin : g_bot
            assign below = '0;
        end else begin : g_up
            assign below = ent[g+1];
        end
        stack_reg_cell #(.WIDTH(WIDTH)) u_cell (
            .sysclk  (sysclk),
            .sysreset(sysreset),
            .sel_i   (sel[g]),
            .above_i (above),
            .below_i (below),
            .q_o     (ent[g])
        );
    end

    always_comb begin
        count_d = count_q;
        case (op_eff)
            OP_PUSH: count_d = full ? count_q : count_q + 1'b1;
            OP_POP:  count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // An error event in the same cycle as clear_err still leaves the flag set.
    assign ovf_d = (op_raw == OP_PUSH && full)  | (ovf_q & ~bus.clear_err);
    assign unf_d = (op_raw == OP_POP  && empty) | (unf_q & ~bus.clear_err);

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.data_out  = ent[0];
    assign bus.count     = count_q;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

`ifdef STACK_REG_PEEK_EN
    // Compare-select rather than direct indexing so an index past DEPTH
    // reads 0 without an out-of-range access.
    always_comb begin
        bus.peek_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (int'(bus.peek_idx) == i) bus.peek_data = ent[i];
    end
`endif
endmodule
